// File: rtl/riscv_lsu.sv
// riscv_lsu - load/store unit controller for the RV32 core.
//
// Takes one memory operation at a time from the EX stage and runs it over a
// req/gnt/rvalid data-memory bus. Returns load data lane-aligned and sign- or
// zero-extended by funct3. Builds byte strobes and lane-replicated store data.
// Misaligned accesses and illegal funct3 answer with an error response and
// never touch the bus.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid_i / req_ready_o  EX-side handshake (ready only while idle)
//   req_we_i, req_funct3_i     store/load select and size/signedness
//   req_addr_i, req_wdata_i    byte address and right-justified store data
//   rsp_valid_o                one-cycle response pulse
//   rsp_rdata_o, rsp_err_o     extended load data (0 for stores/errors), error flag
//   mem_req_o / mem_gnt_i      bus request and grant
//   mem_we_o, mem_addr_o       bus write enable, word address
//   mem_be_o, mem_wdata_o      byte enables, lane-replicated write data
//   mem_rvalid_i, mem_rdata_i  bus completion and read word
module riscv_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

  state_t          state_reg, state_next;
  logic            we_reg;
  logic [2:0]      funct3_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            rsp_valid_reg;
  logic [XLEN-1:0] rsp_rdata_reg, rsp_rdata_next;

  logic            req_illegal;
  logic            req_misaligned;
  logic            req_err;
  logic [3:0]      be_base;
  logic [3:0]      be_shifted;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] rdata_shifted;
  logic [XLEN-1:0] load_data;

  // Error check is done on the incoming request so the decision is made in
  // the accept cycle and the error pulse can follow one cycle later.
  always_comb begin
    if (req_we_i)
      req_illegal = !(req_funct3_i == 3'b000 || req_funct3_i == 3'b001 ||
                      req_funct3_i == 3'b010);
    else
      req_illegal = !(req_funct3_i == 3'b000 || req_funct3_i == 3'b001 ||
                      req_funct3_i == 3'b010 || req_funct3_i == 3'b100 ||
                      req_funct3_i == 3'b101);
  end

  assign req_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                          ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  assign req_err = req_illegal || req_misaligned;

  // Strobes from the latched operation; word accesses are aligned so the
  // shift is a no-op for them.
  always_comb begin
    case (funct3_reg[1:0])
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
  end
  assign be_shifted = be_base << addr_reg[1:0];

  // Lane replication: bytes go to every lane, halfwords to both halves, so
  // the memory picks the right lane purely by byte enable.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_rep[8*gi +: 8] =
        (funct3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
        (funct3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                     wdata_reg[8*gi +: 8];
    end
  endgenerate

  assign rdata_shifted = mem_rdata_i >> {addr_reg[1:0], 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  load_data = {{(XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_data = {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, rdata_shifted[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  // Response data register is rewritten every cycle, so it reads 0 except in
  // the pulse that follows a load completion.
  always_comb begin
    rsp_rdata_next = '0;
    if (state_reg == WAIT && mem_rvalid_i && !we_reg)
      rsp_rdata_next = load_data;
  end

  always_comb begin
    state_next  = state_reg;
    req_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    rsp_err_o   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i)
          state_next = req_err ? ERR : REQ;
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i)
          state_next = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i)
          state_next = IDLE;
      end
      ERR: begin
        rsp_err_o  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'b000;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid_i) begin
        we_reg     <= req_we_i;
        funct3_reg <= req_funct3_i;
        addr_reg   <= req_addr_i;
        wdata_reg  <= req_wdata_i;
      end
      rsp_valid_reg <= (state_reg == WAIT) && mem_rvalid_i;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  // Bus side-band outputs are forced to 0 outside REQ; inside REQ they come
  // straight from registers and therefore hold steady through a grant stall.
  assign mem_we_o    = mem_req_o && we_reg;
  assign mem_addr_o  = mem_req_o ? {addr_reg[XLEN-1:2], 2'b00} : '0;
  assign mem_be_o    = mem_req_o ? be_shifted : 4'b0000;
  assign mem_wdata_o = mem_req_o ? wdata_rep : '0;

  assign rsp_valid_o = rsp_valid_reg || (state_reg == ERR);
  assign rsp_rdata_o = rsp_rdata_reg;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu - directed self-checking bench for riscv_lsu.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  riscv_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full bus transaction. gnt_dly/rv_dly are stall cycles before grant/rvalid.
  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                       input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    tick();
    req_valid_i = 1'b0;
    req_wdata_i = 32'h0;
    for (int i = 0; i <= gnt_dly; i++) begin
      chk({tag, " mem_req"}, {31'b0, mem_req_o}, 32'h1);
      chk({tag, " ready"}, {31'b0, req_ready_o}, 32'h0);
      chk({tag, " addr"}, mem_addr_o, {addr[31:2], 2'b00});
      chk({tag, " be"}, {28'b0, mem_be_o}, {28'b0, exp_be});
      chk({tag, " we"}, {31'b0, mem_we_o}, {31'b0, we});
      if (we) chk({tag, " wdata"}, mem_wdata_o, exp_wdata);
      if (i < gnt_dly) tick();
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk({tag, " wait mem_req"}, {31'b0, mem_req_o}, 32'h0);
    for (int i = 0; i < rv_dly; i++) begin
      chk({tag, " early rsp"}, {31'b0, rsp_valid_o}, 32'h0);
      tick();
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    chk({tag, " rsp_valid"}, {31'b0, rsp_valid_o}, 32'h1);
    chk({tag, " rsp_err"}, {31'b0, rsp_err_o}, 32'h0);
    chk({tag, " rdata"}, rsp_rdata_o, exp_rdata);
    chk({tag, " ready after"}, {31'b0, req_ready_o}, 32'h1);
    tick();
    chk({tag, " pulse end"}, {31'b0, rsp_valid_o}, 32'h0);
    $display("op %s we=%0b f3=%0d addr=0x%08h rdata=0x%08h", tag, we, f3, addr, exp_rdata);
  endtask

  // Operation expected to be rejected without any bus activity.
  task automatic err_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = 32'h1234_5678;
    tick();
    req_valid_i = 1'b0;
    chk({tag, " rsp_valid"}, {31'b0, rsp_valid_o}, 32'h1);
    chk({tag, " rsp_err"}, {31'b0, rsp_err_o}, 32'h1);
    chk({tag, " rdata"}, rsp_rdata_o, 32'h0);
    chk({tag, " mem_req"}, {31'b0, mem_req_o}, 32'h0);
    tick();
    chk({tag, " pulse end"}, {31'b0, rsp_valid_o}, 32'h0);
    chk({tag, " err end"}, {31'b0, rsp_err_o}, 32'h0);
    chk({tag, " ready"}, {31'b0, req_ready_o}, 32'h1);
    $display("err %s we=%0b f3=%0d addr=0x%08h", tag, we, f3, addr);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b000;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst ready", {31'b0, req_ready_o}, 32'h1);
    chk("rst rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    chk("rst rsp_err", {31'b0, rsp_err_o}, 32'h0);
    chk("rst mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst mem_we", {31'b0, mem_we_o}, 32'h0);
    chk("rst rdata", rsp_rdata_o, 32'h0);
    chk("rst addr", mem_addr_o, 32'h0);
    chk("rst be", {28'b0, mem_be_o}, 32'h0);
    chk("rst wdata", mem_wdata_o, 32'h0);
    $display("reset checked");

    //     tag     we    f3      addr          wdata         g  r  rdata         exp_rdata     be       wdata
    do_op("LB",   1'b0, 3'b000, 32'h0000_1002, 32'h0,        0, 0, 32'h1280_3456, 32'hFFFF_FF80, 4'b0100, 32'h0);
    do_op("LBU",  1'b0, 3'b100, 32'h0000_1003, 32'h0,        0, 0, 32'h1280_3456, 32'h0000_0012, 4'b1000, 32'h0);
    do_op("LHU",  1'b0, 3'b101, 32'h0000_2002, 32'h0,        0, 0, 32'h8001_0000, 32'h0000_8001, 4'b1100, 32'h0);
    do_op("LH",   1'b0, 3'b001, 32'h0000_2002, 32'h0,        0, 1, 32'h8001_0000, 32'hFFFF_8001, 4'b1100, 32'h0);
    do_op("LH0",  1'b0, 3'b001, 32'h0000_2000, 32'h0,        1, 0, 32'h8001_7FFE, 32'h0000_7FFE, 4'b0011, 32'h0);
    do_op("LW",   1'b0, 3'b010, 32'h0000_4000, 32'h0,        0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 32'h0);
    do_op("SB",   1'b1, 3'b000, 32'h0000_3003, 32'hDEAD_BEEF, 0, 0, 32'h5555_5555, 32'h0,        4'b1000, 32'hEFEF_EFEF);
    do_op("SH",   1'b1, 3'b001, 32'h0000_3002, 32'hDEAD_BEEF, 0, 0, 32'h5555_5555, 32'h0,        4'b1100, 32'hBEEF_BEEF);
    do_op("SW",   1'b1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 4, 2, 32'h5555_5555, 32'h0,        4'b1111, 32'hDEAD_BEEF);

    err_op("LW mis",  1'b0, 3'b010, 32'h0000_4001);
    err_op("L f3=3",  1'b0, 3'b011, 32'h0000_4000);
    err_op("S f3=4",  1'b1, 3'b100, 32'h0000_4000);
    err_op("SH mis",  1'b1, 3'b001, 32'h0000_3001);
    err_op("LHU mis", 1'b0, 3'b101, 32'h0000_2003);

    // Reset during WAIT: the later rvalid must not produce a response.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h0000_5000;
    tick();
    req_valid_i = 1'b0;
    chk("rstwait req", {31'b0, mem_req_o}, 32'h1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstwait mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("rstwait ready", {31'b0, req_ready_o}, 32'h1);
    chk("rstwait rsp", {31'b0, rsp_valid_o}, 32'h0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    chk("late rvalid rsp", {31'b0, rsp_valid_o}, 32'h0);
    tick();
    chk("late rvalid rsp2", {31'b0, rsp_valid_o}, 32'h0);
    chk("late rvalid rdata", rsp_rdata_o, 32'h0);
    chk("late rvalid ready", {31'b0, req_ready_o}, 32'h1);
    $display("reset during WAIT checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
